// File: rtl/button_reader.sv
// Four-button sampler: two-flop sync, tick-paced debounce, press encoder,
// and a single-slot valid/ack event register with sticky overrun.
module button_reader #(
  parameter int TICK_DIV   = 250000,
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic       btn_3,
  input  logic       btn_4,
  input  logic       ev_ack,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic       ev_overrun,
  output logic [3:0] btn_level
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CNT - 1);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  logic [3:0]         raw;
  logic [3:0]         s1;
  logic [3:0]         s2;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic [3:0]         lvl_q;
  logic [3:0]         lvl_d;
  logic [3:0]         lvl_prev;
  logic [3:0][SW-1:0] stab_q;
  logic [3:0][SW-1:0] stab_d;
  logic [3:0]         rise;
  logic               any_rise;
  logic               multi;
  logic [1:0]         enc;
  state_t             state_q;
  state_t             state_d;
  logic [1:0]         code_q;
  logic [1:0]         code_d;
  logic               ovr_q;
  logic               ovr_d;

  assign raw  = {btn_4, btn_3, btn_2, btn_1};
  assign tick = (cnt == TMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  // stab counts qualifying ticks minus one; the level flips on the last
  always_comb begin
    lvl_d  = lvl_q;
    stab_d = stab_q;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != lvl_q[i]) begin
          if (stab_q[i] == SMAX) begin
            lvl_d[i]  = s2[i];
            stab_d[i] = '0;
          end else begin
            stab_d[i] = stab_q[i] + SW'(1);
          end
        end else begin
          stab_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q    <= '0;
      lvl_prev <= '0;
      stab_q   <= '0;
    end else begin
      lvl_q    <= lvl_d;
      lvl_prev <= lvl_q;
      stab_q   <= stab_d;
    end
  end

  assign rise     = lvl_q & ~lvl_prev;
  assign any_rise = |rise;
  assign multi    = |(rise & (rise - 4'd1));

  always_comb begin
    enc = 2'd0;
    priority case (1'b1)
      rise[0]: enc = 2'd0;
      rise[1]: enc = 2'd1;
      rise[2]: enc = 2'd2;
      rise[3]: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (any_rise) begin
          state_d = PENDING;
          code_d  = enc;
          ovr_d   = multi;
        end
      end
      PENDING: begin
        if (ev_ack) begin
          if (any_rise) begin
            code_d = enc;
            ovr_d  = multi;
          end else begin
            state_d = IDLE;
            ovr_d   = 1'b0;
          end
        end else if (any_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ev_valid   = (state_q == PENDING);
  assign ev_code    = code_q;
  assign ev_overrun = ovr_q;
  assign btn_level  = lvl_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: cycle model of sync delay, tick-paced
// consecutive-sample debounce and the single-slot event register.
module tb_button_reader;

  localparam int TD = 4;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_1 = 1'b0;
  logic       btn_2 = 1'b0;
  logic       btn_3 = 1'b0;
  logic       btn_4 = 1'b0;
  logic       ev_ack = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_overrun;
  logic [3:0] btn_level;

  always #5 clk = ~clk;

  button_reader #(.TICK_DIV(TD), .STABLE_CNT(SC)) dut (
    .clk(clk),
    .reset(reset),
    .btn_1(btn_1),
    .btn_2(btn_2),
    .btn_3(btn_3),
    .btn_4(btn_4),
    .ev_ack(ev_ack),
    .ev_valid(ev_valid),
    .ev_code(ev_code),
    .ev_overrun(ev_overrun),
    .btn_level(btn_level)
  );

  int n_run = 0;
  int n_fail = 0;

  // reference model state
  int         m_cyc;
  int         m_run [4];
  logic [3:0] m_h1, m_h2, m_lvl, m_prev, m_rise;
  logic       m_pend, m_ovr;
  logic [1:0] m_code;
  logic [3:0] raw;
  logic [7:0] dut_o, mdl_o;

  assign raw    = {btn_4, btn_3, btn_2, btn_1};
  assign m_rise = m_lvl & ~m_prev;
  assign dut_o  = {ev_valid, ev_code, ev_overrun, btn_level};
  assign mdl_o  = {m_pend, m_code, m_ovr, m_lvl};

  function automatic logic [1:0] lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic many(input logic [3:0] r);
    return ($countones(r) > 1);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc  <= 0;
      m_h1   <= '0;
      m_h2   <= '0;
      m_lvl  <= '0;
      m_prev <= '0;
      m_pend <= 1'b0;
      m_code <= '0;
      m_ovr  <= 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      m_h1  <= raw;
      m_h2  <= m_h1;
      if (m_cyc % TD == TD - 1) begin
        for (int i = 0; i < 4; i++) begin
          if (m_h2[i] != m_lvl[i]) begin
            if (m_run[i] + 1 >= SC) begin
              m_lvl[i] <= m_h2[i];
              m_run[i] <= 0;
            end else begin
              m_run[i] <= m_run[i] + 1;
            end
          end else begin
            m_run[i] <= 0;
          end
        end
      end
      m_prev <= m_lvl;
      if (!m_pend) begin
        if (m_rise != 0) begin
          m_pend <= 1'b1;
          m_code <= lowest(m_rise);
          m_ovr  <= many(m_rise);
        end
      end else if (ev_ack) begin
        if (m_rise != 0) begin
          m_code <= lowest(m_rise);
          m_ovr  <= many(m_rise);
        end else begin
          m_pend <= 1'b0;
          m_ovr  <= 1'b0;
        end
      end else if (m_rise != 0) begin
        m_ovr <= 1'b1;
      end
    end
  end

  task automatic test_reset();
    #2 reset = 1'b0;
    #1 n_run++;
    if (dut_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async got %b exp 00000000", dut_o);
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (dut_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold got %b exp 00000000", dut_o);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_press();
    btn_2 = 1'b1;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL single t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
    n_run++;
    if (btn_level !== 4'b0010 || ev_valid !== 1'b1 || ev_code !== 2'd1) begin
      n_fail++;
      $display("FAIL single_ev got l=%b v=%b c=%0d exp l=0010 v=1 c=1",
               btn_level, ev_valid, ev_code);
    end
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
    n_run++;
    if (ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack got v=%b exp 0", ev_valid);
    end
    btn_2 = 1'b0;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL single_rel t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
  endtask

  task automatic test_glitch();
    int   evs = 0;
    logic pv = ev_valid;
    for (int k = 0; k < 36; k++) begin
      btn_3 = !(k >= 8 && k < 12);
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL glitch t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
      if (ev_valid && !pv) evs++;
      pv = ev_valid;
      if (k == 19) begin
        n_run++;
        if (btn_level[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_restart got l2=%b exp 0", btn_level[2]);
        end
      end
    end
    n_run++;
    if (evs != 1 || ev_code !== 2'd2 || btn_level !== 4'b0100) begin
      n_fail++;
      $display("FAIL glitch_ev got n=%0d c=%0d l=%b exp n=1 c=2 l=0100",
               evs, ev_code, btn_level);
    end
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
    btn_3 = 1'b0;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL glitch_rel t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_1 = 1'b1;
    btn_4 = 1'b1;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL simul t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
    n_run++;
    if (ev_valid !== 1'b1 || ev_code !== 2'd0 || ev_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_ev got v=%b c=%0d o=%b exp v=1 c=0 o=1",
               ev_valid, ev_code, ev_overrun);
    end
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
    n_run++;
    if (ev_valid !== 1'b0 || ev_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_ack got v=%b o=%b exp v=0 o=0", ev_valid, ev_overrun);
    end
    btn_1 = 1'b0;
    btn_4 = 1'b0;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL simul_rel t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
  endtask

  task automatic test_ack_with_press();
    logic done = 1'b0;
    btn_4 = 1'b1;
    repeat (20) @(negedge clk);
    btn_2 = 1'b1;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL ackp_ovr t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
    n_run++;
    if (ev_valid !== 1'b1 || ev_code !== 2'd3 || ev_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ackp_drop got v=%b c=%0d o=%b exp v=1 c=3 o=1",
               ev_valid, ev_code, ev_overrun);
    end
    btn_1 = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (btn_level[0]) begin
        ev_ack = 1'b1;
        @(negedge clk);
        ev_ack = 1'b0;
        done = 1'b1;
        n_run++;
        if (ev_valid !== 1'b1 || ev_code !== 2'd0 || ev_overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL ackp_same got v=%b c=%0d o=%b exp v=1 c=0 o=0",
                   ev_valid, ev_code, ev_overrun);
        end
        n_run++;
        if (dut_o !== mdl_o) begin
          n_fail++;
          $display("FAIL ackp_model got %b exp %b", dut_o, mdl_o);
        end
      end
    end
    if (!done) begin
      n_run++;
      n_fail++;
      $display("FAIL ackp_timeout got l=%b exp l[0]=1", btn_level);
    end
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
    {btn_1, btn_2, btn_4} = 3'b000;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL ackp_rel t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
  endtask

  task automatic test_release();
    int   evs = 0;
    logic pv = ev_valid;
    for (int k = 0; k < 42; k++) begin
      btn_4  = (k < 20);
      ev_ack = (k == 20);
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL release t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
      if (ev_valid && !pv) evs++;
      pv = ev_valid;
    end
    ev_ack = 1'b0;
    n_run++;
    if (evs != 1 || btn_level[3] !== 1'b0 || ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_ev got n=%0d l3=%b v=%b exp n=1 l3=0 v=0",
               evs, btn_level[3], ev_valid);
    end
  endtask

  task automatic test_reset_mid();
    btn_4 = 1'b1;
    repeat (20) @(negedge clk);
    btn_1 = 1'b1;
    repeat (20) @(negedge clk);
    btn_2 = 1'b1;
    repeat (6) @(negedge clk);
    n_run++;
    if (ev_overrun !== 1'b1 || ev_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre got v=%b o=%b exp v=1 o=1", ev_valid, ev_overrun);
    end
    reset = 1'b0;
    #1 n_run++;
    if (dut_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_async got %b exp 00000000", dut_o);
    end
    btn_1 = 1'b0;
    btn_4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL rmid t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
    n_run++;
    if (ev_valid !== 1'b1 || ev_code !== 2'd1 || ev_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_ev got v=%b c=%0d o=%b exp v=1 c=1 o=0",
               ev_valid, ev_code, ev_overrun);
    end
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
    btn_2 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] b;
    for (int k = 0; k < 800; k++) begin
      b = raw;
      if ($urandom_range(0, 7) == 0) b[$urandom_range(0, 3)] ^= 1'b1;
      {btn_4, btn_3, btn_2, btn_1} = b;
      ev_ack = ($urandom_range(0, 3) == 0);
      @(negedge clk); n_run++;
      if (dut_o !== mdl_o) begin
        n_fail++;
        $display("FAIL random t=%0t got %b exp %b", $time, dut_o, mdl_o);
      end
    end
    ev_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_ack_with_press();
    test_release();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
